minesweeper_board_arbiter: RTL and testbench

//  Owns the single-port board RAM (one cell per square) and shares it among three clients:
//  the game processor (read/write), the VGA renderer (read-only) and an internal board-clear sequencer.

---
 rtl/minesweeper_pkg.sv | 33 +++
 rtl/minesweeper_board_arbiter.sv | 144 ++++++++++++++
 tb/tb_minesweeper_board_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board logic.
// Holds the board geometry, the cell bit layout, the value a cell takes
// after a board clear, and the small enums used by the board arbiter.
// Cells are declared [0:CELL_W-1], so index 0 is the leftmost (MSB) bit.
package minesweeper_pkg;

  localparam int ADDR_W        = 8;
  localparam int CELL_W        = 7;
  localparam int NUM_CELLS     = 256;
  localparam int MAX_VID_BURST = 3;

  // Cell bit indices in [0:CELL_W-1] order; index 3 is reserved.
  localparam int FLAG_BIT    = 0;
  localparam int COVERED_BIT = 1;
  localparam int BOMB_BIT    = 2;
  localparam int ADJ_MSB     = 4;
  localparam int ADJ_LSB     = 6;

  // Covered, no bomb, no flag, zero adjacent bombs.
  localparam logic [0:CELL_W-1] CLEAR_VALUE = 7'b0100000;

  typedef enum logic [1:0] {
    NONE,
    PROC,
    VID
  } rd_owner_e;

  typedef enum logic {
    ARB,
    CLEAR
  } arb_state_e;

endpackage

// File: rtl/minesweeper_board_arbiter.sv
// Board RAM arbiter for the minesweeper game.
// Shares one single-port, synchronous-read board RAM among the game
// processor (read/write), the VGA renderer (read-only) and an internal
// clear sequencer that writes CLEAR_VALUE into every cell.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   proc_req/we/addr/wdata          processor access request
//   proc_gnt/rvalid/rdata           processor grant and read return
//   vid_req/addr                    renderer read request
//   vid_gnt/rvalid/rdata            renderer grant and read return
//   clr_start, clr_busy, clr_done   board clear control and status
//   mem_addr/we/wdata, mem_rdata    board RAM interface (1-cycle read latency)
module minesweeper_board_arbiter
  import minesweeper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [0:CELL_W-1] proc_wdata,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [0:CELL_W-1] proc_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [0:CELL_W-1] vid_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [0:CELL_W-1] mem_wdata,
  input  logic [0:CELL_W-1] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_VID_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_BURST);
  // One extra counter bit so a full 2**ADDR_W clear ends without wrapping.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(NUM_CELLS - 1);

  arb_state_e          state, state_next;
  logic [ADDR_W:0]     clr_cnt, clr_cnt_next;
  logic [STREAK_W-1:0] vid_streak, vid_streak_next;
  rd_owner_e           rd_owner, rd_owner_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      clr_cnt    <= '0;
      vid_streak <= '0;
      rd_owner   <= NONE;
    end else begin
      state      <= state_next;
      clr_cnt    <= clr_cnt_next;
      vid_streak <= vid_streak_next;
      rd_owner   <= rd_owner_next;
    end
  end

  // Grants are combinational, so they are masked while reset is high to
  // keep every output at 0 for the whole reset window.
  // The video streak counts video wins while the processor waits; once it
  // reaches MAX_VID_BURST the waiting processor takes the next slot.
  always_comb begin
    state_next      = state;
    clr_cnt_next    = clr_cnt;
    vid_streak_next = vid_streak;
    rd_owner_next   = NONE;
    proc_gnt        = 1'b0;
    vid_gnt         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    clr_busy        = 1'b0;
    clr_done        = 1'b0;

    if (!reset) begin
      case (state)
        ARB: begin
          if (clr_start) begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
            if (!proc_req) begin
              vid_streak_next = '0;
            end
          end else if (vid_req && ((vid_streak < STREAK_MAX) || !proc_req)) begin
            vid_gnt       = 1'b1;
            mem_addr      = vid_addr;
            rd_owner_next = VID;
            if (!proc_req) begin
              vid_streak_next = '0;
            end else if (vid_streak < STREAK_MAX) begin
              vid_streak_next = vid_streak + STREAK_W'(1);
            end
          end else if (proc_req) begin
            proc_gnt        = 1'b1;
            mem_addr        = proc_addr;
            vid_streak_next = '0;
            if (proc_we) begin
              mem_we    = 1'b1;
              mem_wdata = proc_wdata;
            end else begin
              rd_owner_next = PROC;
            end
          end else begin
            vid_streak_next = '0;
          end
        end

        CLEAR: begin
          clr_busy  = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clr_cnt[ADDR_W-1:0];
          mem_wdata = CLEAR_VALUE;
          if (!proc_req) begin
            vid_streak_next = '0;
          end
          // A restart wins over completion, so an aborted pass never pulses done.
          if (clr_start) begin
            clr_cnt_next = '0;
          end else if (clr_cnt == CNT_LAST) begin
            clr_done     = 1'b1;
            clr_cnt_next = '0;
            state_next   = ARB;
          end else begin
            clr_cnt_next = clr_cnt + (ADDR_W + 1)'(1);
          end
        end
      endcase
    end
  end

  // Read data is steered to whichever client owned last cycle's read.
  always_comb begin
    proc_rvalid = (rd_owner == PROC);
    vid_rvalid  = (rd_owner == VID);
    proc_rdata  = proc_rvalid ? mem_rdata : '0;
    vid_rdata   = vid_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_minesweeper_board_arbiter.sv
// Self-checking bench for minesweeper_board_arbiter.
// A behavioural board RAM sits on the memory port. Directed table vectors,
// hand-written clear sequences and a randomized phase checked against a
// reference model of the arbitration and clear rules.
module tb_minesweeper_board_arbiter;
  import minesweeper_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              proc_req, proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [0:CELL_W-1] proc_wdata;
  logic              proc_gnt, proc_rvalid;
  logic [0:CELL_W-1] proc_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_rvalid;
  logic [0:CELL_W-1] vid_rdata;
  logic              clr_start, clr_busy, clr_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [0:CELL_W-1] mem_wdata;
  logic [0:CELL_W-1] mem_rdata;

  int checks = 0;
  int failures = 0;

  minesweeper_board_arbiter dut (
    .clk(clk), .reset(reset),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port board RAM with one cycle of read latency.
  logic [0:CELL_W-1] ram [NUM_CELLS];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
  task automatic applyStimulus(input logic p_req, input logic p_we, input logic [7:0] p_addr,
                               input logic [0:6] p_wd, input logic v_req, input logic [7:0] v_addr,
                               input logic c_start);
    @(negedge clk);
    proc_req = p_req; proc_we = p_we; proc_addr = p_addr; proc_wdata = p_wd;
    vid_req = v_req; vid_addr = v_addr; clr_start = c_start;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 0);
  endtask

  // Directed vector table.
  typedef struct {
    logic p_req, p_we; logic [7:0] p_addr; logic [0:6] p_wd; logic v_req; logic [7:0] v_addr;
    logic e_pg, e_vg, e_we; logic [7:0] e_addr; logic e_prv, e_vrv; logic [0:6] e_rdata;
  } vec_t;
  vec_t vecs [11];

  // Reference model state.
  logic [0:6] m_mem [NUM_CELLS];
  bit m_clearing;
  int m_idx;
  int m_waited_vid;
  bit m_prv, m_vrv;
  logic [0:6] m_rdata;
  bit e_pg, e_vg, e_we, e_busy, e_done;
  logic [7:0] e_addr;
  logic [0:6] e_wd;

  // Expected behaviour for one cycle from the current inputs, then advance.
  task automatic modelStep();
    bit n_prv, n_vrv;
    logic [0:6] n_rdata;
    n_prv = 0; n_vrv = 0; n_rdata = '0;
    e_pg = 0; e_vg = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = '0; e_wd = '0;
    if (m_clearing) begin
      e_busy = 1; e_we = 1; e_addr = 8'(m_idx); e_wd = CLEAR_VALUE;
      m_mem[m_idx] = CLEAR_VALUE;
      if (clr_start) m_idx = 0;
      else if (m_idx == NUM_CELLS - 1) begin e_done = 1; m_clearing = 0; end
      else m_idx = m_idx + 1;
    end else if (clr_start) begin
      m_clearing = 1; m_idx = 0;
    end else if (vid_req && (m_waited_vid < MAX_VID_BURST || !proc_req)) begin
      e_vg = 1; e_addr = vid_addr; n_vrv = 1; n_rdata = m_mem[vid_addr];
    end else if (proc_req) begin
      e_pg = 1; e_addr = proc_addr;
      if (proc_we) begin e_we = 1; e_wd = proc_wdata; m_mem[proc_addr] = proc_wdata; end
      else begin n_prv = 1; n_rdata = m_mem[proc_addr]; end
    end
    if (!proc_req || e_pg) m_waited_vid = 0;
    else if (e_vg) m_waited_vid = m_waited_vid + 1;
    m_prv = n_prv; m_vrv = n_vrv; m_rdata = n_rdata;
  endtask

  initial begin
    int busy_cycles, done_at, done_count, gnt_at;
    bit addr_ok, held_p, held_v;

    // Reset state
    reset = 1;
    proc_req = 0; proc_we = 0; proc_addr = '0; proc_wdata = '0;
    vid_req = 0; vid_addr = '0; clr_start = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset proc_gnt", proc_gnt, 0);
    checkOutput("reset vid_gnt", vid_gnt, 0);
    checkOutput("reset mem_we", mem_we, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset clr_busy", clr_busy, 0);
    checkOutput("reset rvalids", {proc_rvalid, vid_rvalid}, 0);
    @(negedge clk);
    reset = 0;

    // Directed table: write/read, video burst fairness, read return steering
    vecs[0]  = '{1,1,8'h12,7'h55, 0,8'h00, 1,0,1,8'h12, 0,0,7'h00};
    vecs[1]  = '{1,0,8'h12,7'h00, 0,8'h00, 1,0,0,8'h12, 0,0,7'h00};
    vecs[2]  = '{0,0,8'h00,7'h00, 0,8'h00, 0,0,0,8'h00, 1,0,7'h55};
    vecs[3]  = '{1,1,8'h20,7'h0A, 1,8'h12, 0,1,0,8'h12, 0,0,7'h00};
    vecs[4]  = '{1,1,8'h20,7'h0A, 1,8'h12, 0,1,0,8'h12, 0,1,7'h55};
    vecs[5]  = '{1,1,8'h20,7'h0A, 1,8'h12, 0,1,0,8'h12, 0,1,7'h55};
    vecs[6]  = '{1,1,8'h20,7'h0A, 1,8'h12, 1,0,1,8'h20, 0,1,7'h55};
    vecs[7]  = '{1,0,8'h12,7'h00, 1,8'h20, 0,1,0,8'h20, 0,0,7'h00};
    vecs[8]  = '{1,0,8'h12,7'h00, 0,8'h00, 1,0,0,8'h12, 0,1,7'h0A};
    vecs[9]  = '{0,0,8'h00,7'h00, 1,8'h12, 0,1,0,8'h12, 1,0,7'h55};
    vecs[10] = '{0,0,8'h00,7'h00, 0,8'h00, 0,0,0,8'h00, 0,1,7'h55};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].p_req, vecs[i].p_we, vecs[i].p_addr, vecs[i].p_wd,
                    vecs[i].v_req, vecs[i].v_addr, 0);
      checkOutput($sformatf("vec%0d proc_gnt", i), proc_gnt, vecs[i].e_pg);
      checkOutput($sformatf("vec%0d vid_gnt", i), vid_gnt, vecs[i].e_vg);
      checkOutput($sformatf("vec%0d mem_we", i), mem_we, vecs[i].e_we);
      checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_we ? vecs[i].p_wd : 7'h00);
      checkOutput($sformatf("vec%0d proc_rvalid", i), proc_rvalid, vecs[i].e_prv);
      checkOutput($sformatf("vec%0d vid_rvalid", i), vid_rvalid, vecs[i].e_vrv);
      if (vecs[i].e_prv) checkOutput($sformatf("vec%0d proc_rdata", i), proc_rdata, vecs[i].e_rdata);
      if (vecs[i].e_vrv) checkOutput($sformatf("vec%0d vid_rdata", i), vid_rdata, vecs[i].e_rdata);
    end

    // Both clients held: pattern V,V,V,P repeating
    idleCycle();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 8'h40, 7'h01, 1, 8'h41, 0);
      checkOutput($sformatf("burst%0d proc_gnt", i), proc_gnt, (i % 4) == 3);
      checkOutput($sformatf("burst%0d vid_gnt", i), vid_gnt, (i % 4) != 3);
    end
    idleCycle();

    // Full clear: 256 busy cycles, done on the last one, every cell cleared
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    checkOutput("clr start no grant", {proc_gnt, vid_gnt, mem_we}, 0);
    busy_cycles = 0; done_at = -1; done_count = 0; addr_ok = 1;
    for (int i = 0; i < 300; i++) begin
      idleCycle();
      if (!clr_busy) break;
      if (mem_addr != 8'(busy_cycles) || !mem_we || mem_wdata != CLEAR_VALUE) addr_ok = 0;
      busy_cycles++;
      if (clr_done) begin done_at = busy_cycles; done_count++; end
    end
    checkOutput("clear busy cycles", busy_cycles, 256);
    checkOutput("clear done position", done_at, 256);
    checkOutput("clear done count", done_count, 1);
    checkOutput("clear write sequence", addr_ok, 1);
    for (int k = 0; k <= NUM_CELLS; k++) begin
      if (k < NUM_CELLS) applyStimulus(1, 0, 8'(k), 7'h00, 0, 8'h00, 0);
      else idleCycle();
      if (k > 0) begin
        checkOutput($sformatf("clear cell %0d rvalid", k - 1), proc_rvalid, 1);
        checkOutput($sformatf("clear cell %0d value", k - 1), proc_rdata, CLEAR_VALUE);
      end
    end

    // Processor held during clear: granted only the cycle after clr_done
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    gnt_at = -1; done_at = -1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 8'h33, 7'h11, 0, 8'h00, 0);
      if (clr_done) done_at = i;
      if (proc_gnt) begin
        gnt_at = i;
        checkOutput("clr proc gnt while busy", clr_busy, 0);
        checkOutput("clr proc write addr", mem_addr, 8'h33);
        break;
      end
    end
    checkOutput("clr proc done cycle", done_at, 255);
    checkOutput("clr proc grant cycle", gnt_at, 256);
    applyStimulus(1, 0, 8'h33, 7'h00, 0, 8'h00, 0);
    idleCycle();
    checkOutput("clr proc readback rvalid", proc_rvalid, 1);
    checkOutput("clr proc readback data", proc_rdata, 7'h11);

    // Restart at clr_cnt=100: done exactly 256 cycles after the restart
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    for (int i = 0; i < 100; i++) idleCycle();
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    checkOutput("restart cnt at 100", mem_addr, 8'd100);
    done_at = -1; done_count = 0;
    for (int j = 1; j <= 300; j++) begin
      idleCycle();
      if (j == 1) checkOutput("restart cnt at 0", mem_addr, 8'd0);
      if (clr_done) begin done_count++; if (done_at < 0) done_at = j; end
      if (!clr_busy) break;
    end
    checkOutput("restart done offset", done_at, 256);
    checkOutput("restart done count", done_count, 1);

    // Reset mid-clear at clr_cnt=50
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    for (int i = 0; i < 50; i++) idleCycle();
    applyStimulus(1, 0, 8'h05, 7'h00, 1, 8'h07, 0);
    checkOutput("midclear cnt at 50", mem_addr, 8'd50);
    reset = 1;
    #1;
    checkOutput("reset mid outputs", {proc_gnt, vid_gnt, mem_we, clr_busy, clr_done,
                                      proc_rvalid, vid_rvalid}, 0);
    checkOutput("reset mid mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 0;
    applyStimulus(0, 0, 8'h00, 7'h00, 1, 8'h07, 0);
    checkOutput("post reset vid_gnt", vid_gnt, 1);
    checkOutput("post reset busy", clr_busy, 0);
    checkOutput("post reset mem_addr", mem_addr, 8'h07);
    idleCycle();
    checkOutput("post reset vid_rvalid", vid_rvalid, 1);

    // Randomized phase against the reference model, from a freshly cleared board
    applyStimulus(0, 0, 8'h00, 7'h00, 0, 8'h00, 1);
    for (int i = 0; i < 300; i++) begin
      idleCycle();
      if (!clr_busy) break;
    end
    checkOutput("random prep idle", clr_busy, 0);
    for (int i = 0; i < NUM_CELLS; i++) m_mem[i] = CLEAR_VALUE;
    m_clearing = 0; m_idx = 0; m_waited_vid = 0; m_prv = 0; m_vrv = 0; m_rdata = '0;
    held_p = 0; held_v = 0;
    for (int c = 0; c < 3000; c++) begin
      logic np_req, np_we, nv_req, nc;
      logic [7:0] np_addr, nv_addr;
      logic [0:6] np_wd;
      if (held_p) begin
        np_req = 1; np_we = proc_we; np_addr = proc_addr; np_wd = proc_wdata;
      end else begin
        np_req = ($urandom_range(0, 9) < 6); np_we = $urandom_range(0, 1);
        np_addr = 8'($urandom); np_wd = 7'($urandom);
      end
      if (held_v) begin
        nv_req = 1; nv_addr = vid_addr;
      end else begin
        nv_req = ($urandom_range(0, 9) < 6); nv_addr = 8'($urandom);
      end
      nc = ($urandom_range(0, 399) == 0);
      applyStimulus(np_req, np_we, np_addr, np_wd, nv_req, nv_addr, nc);
      checkOutput("rand proc_rvalid", proc_rvalid, m_prv);
      checkOutput("rand vid_rvalid", vid_rvalid, m_vrv);
      if (m_prv) checkOutput("rand proc_rdata", proc_rdata, m_rdata);
      if (m_vrv) checkOutput("rand vid_rdata", vid_rdata, m_rdata);
      modelStep();
      checkOutput("rand proc_gnt", proc_gnt, e_pg);
      checkOutput("rand vid_gnt", vid_gnt, e_vg);
      checkOutput("rand mem_we", mem_we, e_we);
      checkOutput("rand mem_addr", mem_addr, e_addr);
      checkOutput("rand mem_wdata", mem_wdata, e_wd);
      checkOutput("rand clr_busy", clr_busy, e_busy);
      checkOutput("rand clr_done", clr_done, e_done);
      held_p = np_req && !e_pg;
      held_v = nv_req && !e_vg;
    end
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
